// File: rtl/cbuffer_pkg.sv
// Shared sizing helpers, default parameters and state encoding for cbuffer_mc.
// Defining CBUF_ZERO_FILL_EN adds the INIT (memory clear) state.
package cbuffer_pkg;

    localparam int DEF_DATA_WIDTH = 48;
    localparam int DEF_ADDR_WIDTH = 8;
    localparam int DEF_NUM_CH     = 2;
    localparam int DEF_TAPS       = 128;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    // A single channel still needs a one-bit select port.
    function automatic int ch_width(input int num_ch);
        return (num_ch > 1) ? clog2(num_ch) : 1;
    endfunction

`ifdef CBUF_ZERO_FILL_EN
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_BURST = 2'd1, ST_INIT = 2'd2} cb_state_e;
`else
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_BURST = 2'd1} cb_state_e;
`endif

endpackage

// File: rtl/cbuffer_ram.sv
// Simple dual-port sample store: one write port, one registered read port.
// The read register resets to zero and holds its value when no read is issued.
module cbuffer_ram #(
    parameter int DW = 48,
    parameter int AW = 9
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)  rdata <= '0;
        else if (re)   rdata <= mem[raddr];
    end

endmodule

// File: rtl/cbuffer_mc.sv
// Multi-channel circular sample buffer with newest-to-oldest read bursts of TAPS samples.
// Defining CBUF_ZERO_FILL_EN clears the whole memory after reset before accepting traffic.
module cbuffer_mc
    import cbuffer_pkg::*;
#(
    parameter int  DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int  ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int  NUM_CH     = DEF_NUM_CH,
    parameter int  TAPS       = DEF_TAPS,
    localparam int CH_WIDTH   = ch_width(NUM_CH)
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic signed [DATA_WIDTH-1:0] data_in,
    input  logic        [CH_WIDTH-1:0]   wr_ch,
    input  logic                         wren,
    input  logic                         rd_start,
    input  logic        [CH_WIDTH-1:0]   rd_ch,
    output logic                         ready,
    output logic                         busy,
    output logic signed [DATA_WIDTH-1:0] data_out,
    output logic                         out_valid,
    output logic                         out_last
);

    localparam int MEM_AW = CH_WIDTH + ADDR_WIDTH;
    localparam int CNT_W  = clog2(TAPS + 1);

    cb_state_e                            state;
    logic [NUM_CH-1:0][ADDR_WIDTH-1:0]    wr_ptr;
    logic [ADDR_WIDTH-1:0]                rd_addr, start_addr;
    logic [CH_WIDTH-1:0]                  rd_chl;
    logic [CNT_W-1:0]                     cnt;
    logic                                 wr_ok, rd_ok, burst_rd;
    logic                                 ram_we, ram_re;
    logic [MEM_AW-1:0]                    ram_waddr, ram_raddr;
    logic [DATA_WIDTH-1:0]                ram_wdata, ram_rdata;

    assign wr_ok      = wren && ready && (int'(wr_ch) < NUM_CH);
    assign rd_ok      = rd_start && ready && (state == ST_IDLE) && (int'(rd_ch) < NUM_CH);
    assign burst_rd   = (state == ST_BURST) && (int'(cnt) < TAPS);
    assign start_addr = wr_ptr[rd_ch] - ADDR_WIDTH'(1);

    // The first read is issued on the accepting edge so data lands one cycle later.
    assign ram_re    = rd_ok || burst_rd;
    assign ram_raddr = rd_ok ? {rd_ch, start_addr} : {rd_chl, rd_addr};

`ifdef CBUF_ZERO_FILL_EN
    localparam int WORDS = NUM_CH * (1 << ADDR_WIDTH);
    logic [MEM_AW-1:0] init_cnt;

    assign ram_we    = (state == ST_INIT) || wr_ok;
    assign ram_waddr = (state == ST_INIT) ? init_cnt : {wr_ch, wr_ptr[wr_ch]};
    assign ram_wdata = (state == ST_INIT) ? '0 : data_in;
`else
    assign ram_we    = wr_ok;
    assign ram_waddr = {wr_ch, wr_ptr[wr_ch]};
    assign ram_wdata = data_in;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)   wr_ptr <= '0;
        else if (wr_ok) wr_ptr[wr_ch] <= wr_ptr[wr_ch] + ADDR_WIDTH'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
`ifdef CBUF_ZERO_FILL_EN
            state    <= ST_INIT;
            init_cnt <= '0;
`else
            state    <= ST_IDLE;
`endif
            ready     <= 1'b0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            rd_addr   <= '0;
            rd_chl    <= '0;
            cnt       <= '0;
        end else begin
`ifndef CBUF_ZERO_FILL_EN
            ready <= 1'b1;
`endif
            case (state)
`ifdef CBUF_ZERO_FILL_EN
                ST_INIT: begin
                    init_cnt <= init_cnt + MEM_AW'(1);
                    if (init_cnt == MEM_AW'(WORDS - 1)) begin
                        state <= ST_IDLE;
                        ready <= 1'b1;
                    end
                end
`endif
                ST_IDLE: begin
                    if (rd_ok) begin
                        state     <= ST_BURST;
                        busy      <= 1'b1;
                        out_valid <= 1'b1;
                        out_last  <= (TAPS == 1);
                        rd_chl    <= rd_ch;
                        rd_addr   <= start_addr - ADDR_WIDTH'(1);
                        cnt       <= CNT_W'(1);
                    end
                end
                ST_BURST: begin
                    if (burst_rd) begin
                        rd_addr  <= rd_addr - ADDR_WIDTH'(1);
                        cnt      <= cnt + CNT_W'(1);
                        out_last <= (int'(cnt) + 1 == TAPS);
                    end else begin
                        // Last sample was presented this cycle.
                        state     <= ST_IDLE;
                        busy      <= 1'b0;
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    cbuffer_ram #(.DW(DATA_WIDTH), .AW(MEM_AW)) u_ram (
        .clk     (clk),
        .reset_n (reset_n),
        .we      (ram_we),
        .waddr   (ram_waddr),
        .wdata   (ram_wdata),
        .re      (ram_re),
        .raddr   (ram_raddr),
        .rdata   (ram_rdata)
    );

    assign data_out = ram_rdata;

endmodule

// File: tb/tb_cbuffer_mc.sv
// Bench for cbuffer_mc: write-history model checked every cycle plus literal burst expectations.
// Honours CBUF_ZERO_FILL_EN when the design is built with it.
module tb_cbuffer_mc;

    localparam int DW = 48, AW = 4, NCH = 2, TAPS = 8, DEPTH = 16;
`ifdef CBUF_ZERO_FILL_EN
    localparam int RDY_LAT = NCH * DEPTH;
`else
    localparam int RDY_LAT = 1;
`endif

    logic                 clk = 1'b0, reset_n = 1'b1;
    logic signed [DW-1:0] data_in = '0;
    logic [0:0]           wr_ch = '0, rd_ch = '0;
    logic                 wren = 1'b0, rd_start = 1'b0;
    logic                 ready, busy, out_valid, out_last;
    logic signed [DW-1:0] data_out;

    int n_cmp = 0, n_bad = 0;

    cbuffer_mc #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_CH(NCH), .TAPS(TAPS)) dut (
        .clk(clk), .reset_n(reset_n), .data_in(data_in), .wr_ch(wr_ch), .wren(wren),
        .rd_start(rd_start), .rd_ch(rd_ch), .ready(ready), .busy(busy),
        .data_out(data_out), .out_valid(out_valid), .out_last(out_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: full write history per channel; a burst returns the last TAPS writes of that channel.
    int unsigned   hch[$];
    logic [DW-1:0] hval[$];
    logic [DW-1:0] pv[$];
    bit            pk[$];
    bit            m_ready = 0, m_busy = 0, m_ov = 0, m_last = 0, m_dc = 0;
    logic [DW-1:0] m_dout = '0;
    int            m_init = 0, m_idx;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_ready = 0; m_busy = 0; m_ov = 0; m_last = 0; m_dout = '0; m_dc = 0;
            pv.delete(); pk.delete(); hch.delete(); hval.delete();
`ifdef CBUF_ZERO_FILL_EN
            m_init = NCH * DEPTH;
            for (int c = 0; c < NCH; c++)
                for (int i = 0; i < DEPTH; i++) begin
                    hch.push_back(c); hval.push_back('0);
                end
`endif
        end else if (m_init > 0) begin
            m_init--;
            if (m_init == 0) m_ready = 1;
        end else begin
            if (rd_start && m_ready && !m_busy && int'(rd_ch) < NCH) begin
                m_idx = hch.size() - 1;
                for (int k = 0; k < TAPS; k++) begin
                    while (m_idx >= 0 && hch[m_idx] != rd_ch) m_idx--;
                    if (m_idx >= 0) begin pv.push_back(hval[m_idx]); pk.push_back(1); m_idx--; end
                    else begin pv.push_back('0); pk.push_back(0); end
                end
            end
            if (wren && m_ready && int'(wr_ch) < NCH) begin
                hch.push_back(wr_ch); hval.push_back(data_in);
            end
            if (pv.size() > 0) begin
                m_ov = 1; m_busy = 1; m_dout = pv.pop_front(); m_dc = !pk.pop_front();
                m_last = (pv.size() == 0);
            end else begin
                m_ov = 0; m_busy = 0; m_last = 0;
            end
            m_ready = 1;
        end
    end

    logic [DW-1:0] cap[$];
    int            busy_n = 0, last_n = 0;
    logic [DW-1:0] last_val = '0;

    always @(negedge clk) begin
        chk("ready", ready, m_ready);
        chk("busy", busy, m_busy);
        chk("out_valid", out_valid, m_ov);
        chk("out_last", out_last, m_last);
        if (!m_dc) chk("data_out", data_out, m_dout);
        if (out_valid) cap.push_back(data_out);
        if (busy) busy_n++;
        if (out_last) begin last_n++; last_val = data_out; end
    end

    task automatic step(); @(posedge clk); #1; endtask

    task automatic wr(input logic c, input logic [DW-1:0] v);
        wren = 1; wr_ch = c; data_in = v; step(); wren = 0;
    endtask

    task automatic clear_obs(); cap.delete(); busy_n = 0; last_n = 0; endtask

    task automatic burst(input logic c);
        clear_obs(); rd_start = 1; rd_ch = c; step(); rd_start = 0;
        repeat (TAPS + 2) step();
    endtask

    task automatic check_desc(input string nm, input logic [DW-1:0] first, input int stepv, input int n);
        chk({nm, " count"}, cap.size(), TAPS);
        for (int k = 0; k < n; k++)
            if (k < cap.size()) chk(nm, cap[k], first - DW'(k * stepv));
    endtask

    task automatic wait_ready();
        int cyc;
        cyc = 0;
        while (!ready && cyc < 200) begin step(); cyc++; end
        chk("ready latency", cyc, RDY_LAT);
    endtask

    task automatic do_reset();
        reset_n = 0; #1;
        chk("rst ready", ready, 0); chk("rst busy", busy, 0); chk("rst out_valid", out_valid, 0);
        chk("rst out_last", out_last, 0); chk("rst data_out", data_out, 0);
        step(); step(); reset_n = 1;
        wait_ready();
    endtask

    int n900;

    initial begin
        #1 do_reset();

        // Linear fill past one wrap of the ring.
        for (int n = 1; n <= 20; n++) wr(0, DW'(n));
        burst(0);
        check_desc("033 burst", 20, 1, TAPS);
        chk("033 busy cycles", busy_n, TAPS);
        chk("033 last count", last_n, 1);
        chk("033 last value", last_val, 13);

        // Read address wraps below zero.
        do_reset();
        wr(0, 1); wr(0, 2); wr(0, 3);
        burst(0);
        check_desc("034 wrap", 3, 1, 3);

        // Channels are independent.
        for (int n = 1; n <= 10; n++) begin wr(0, DW'(100 + n)); wr(1, DW'(200 + n)); end
        burst(1);
        check_desc("035 ch1", 210, 1, TAPS);

        // Concurrent writes to the burst channel and an ignored re-request.
        clear_obs();
        for (int k = 0; k < 10; k++) begin
            wren = 1; wr_ch = 0; data_in = DW'(900 + k);
            rd_start = (k == 0 || k == 3); rd_ch = 0;
            step();
        end
        wren = 0; rd_start = 0;
        repeat (4) step();
        check_desc("036 snapshot", 110, 1, TAPS);
        n900 = 0;
        foreach (cap[i]) if (cap[i] >= 900 && cap[i] < 1000) n900++;
        chk("036 no new data", n900, 0);
        chk("036 busy cycles", busy_n, TAPS);
        chk("036 last count", last_n, 1);

        // Reset at the fourth output sample.
        clear_obs();
        rd_start = 1; rd_ch = 1; step(); rd_start = 0;
        repeat (3) step();
        #1;
        chk("037 valid before drop", out_valid, 1);
        chk("037 samples before drop", cap.size(), 3);
        do_reset();
        repeat (TAPS + 2) step();
        chk("037 no stray output", cap.size(), 3);
`ifdef CBUF_ZERO_FILL_EN
        burst(0);
        check_desc("037 zero fill", 0, 0, TAPS);
`endif

        // Signed samples spanning zero.
        for (int k = 0; k < TAPS; k++) wr(1, DW'(k - 4));
        burst(1);
        check_desc("signed burst", DW'(3), 1, TAPS);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1);
    end

endmodule
